// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: frame states, parity
// selector values, default word width and the majority helper.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int DEF_DATA_WIDTH = 8;

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Captures the serial line at the three edges around mid-bit (h-1, h, h+1,
// h = prescale/2) and presents their majority as the bit value.
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int PRESC_W = 5
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en_i,
  input  logic               rx_i,
  input  logic [PRESC_W-1:0] prescale_i,
  input  logic [PRESC_W-1:0] edge_count_i,
  output logic               bit_o
);

  logic [PRESC_W-1:0] half;
  logic [PRESC_W-1:0] tap_edge [3];
  logic [2:0]         samples_q;
  logic [2:0]         hit;

  assign half = prescale_i >> 1;

  for (genvar gi = 0; gi < 3; gi++) begin : gen_tap
    assign tap_edge[gi] = half + PRESC_W'(gi) - PRESC_W'(1);
    assign hit[gi]      = en_i && (edge_count_i == tap_edge[gi]);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      samples_q <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (hit[i]) samples_q[i] <= rx_i;
      end
    end
  end

  assign bit_o = maj3(samples_q);

endmodule

// File: rtl/uart_rx_fsm.sv
// Frame controller of the UART receiver: tracks start/data/parity/stop bits,
// enables the edge/bit counter, assembles the word and reports frame status.
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PRESC_W    = 5
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  RX_IN,
  input  logic [PRESC_W-1:0]    Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [3:0]            bit_count,
  input  logic [PRESC_W-1:0]    edge_count,
  input  logic                  Last_edge,
  output logic                  count_EN,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  Parity_Error,
  output logic                  Stop_Error
);

  localparam logic [3:0] LAST_DATA_IDX = 4'(DATA_WIDTH);

  rx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  perr_q, perr_d;
  logic                  dv_q, dv_d;
  logic                  pe_q, pe_d;
  logic                  se_q, se_d;
  logic                  sampled_bit;

  uart_rx_sampler #(
    .PRESC_W(PRESC_W)
  ) u_sampler (
    .clk_i       (CLK),
    .rst_ni      (Reset),
    .en_i        (count_EN),
    .rx_i        (RX_IN),
    .prescale_i  (Prescale),
    .edge_count_i(edge_count),
    .bit_o       (sampled_bit)
  );

  assign count_EN = (state_q != ST_IDLE);

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    p_data_d  = p_data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    perr_d    = perr_q;
    dv_d      = 1'b0;
    pe_d      = 1'b0;
    se_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!RX_IN) begin
          state_d   = ST_START;
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
          perr_d    = 1'b0;
        end
      end
      ST_START: begin
        // A start bit that votes high was a glitch; dropping to IDLE clears the counter.
        if (Last_edge) state_d = sampled_bit ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (Last_edge) begin
          shift_d = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
          if (bit_count == LAST_DATA_IDX) state_d = par_en_q ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (Last_edge) begin
          perr_d  = sampled_bit != ((^shift_q) ^ par_typ_q);
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (Last_edge) begin
          state_d = ST_IDLE;
          if (perr_q || !sampled_bit) begin
            pe_d = perr_q;
            se_d = !sampled_bit;
          end else begin
            dv_d     = 1'b1;
            p_data_d = shift_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      p_data_q  <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      perr_q    <= 1'b0;
      dv_q      <= 1'b0;
      pe_q      <= 1'b0;
      se_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      p_data_q  <= p_data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      perr_q    <= perr_d;
      dv_q      <= dv_d;
      pe_q      <= pe_d;
      se_q      <= se_d;
    end
  end

  assign P_DATA       = p_data_q;
  assign Data_Valid   = dv_q;
  assign Parity_Error = pe_q;
  assign Stop_Error   = se_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm with a behavioural edge/bit counter and a
// pulse monitor; expected words and pulse counts are written out per frame.
module tb_uart_rx_fsm;

  logic       CLK = 1'b0;
  logic       Reset;
  logic       RX_IN;
  logic [4:0] Prescale;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [3:0] bit_count;
  logic [4:0] edge_count;
  logic       Last_edge;
  logic       count_EN;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       Parity_Error;
  logic       Stop_Error;

  int n_checks = 0;
  int n_fail   = 0;
  int dv_cnt   = 0;
  int pe_cnt   = 0;
  int se_cnt   = 0;
  logic [7:0] last_data = 8'h00;
  int b_dv, b_pe, b_se;

  uart_rx_fsm dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .RX_IN       (RX_IN),
    .Prescale    (Prescale),
    .PAR_EN      (PAR_EN),
    .PAR_TYP     (PAR_TYP),
    .bit_count   (bit_count),
    .edge_count  (edge_count),
    .Last_edge   (Last_edge),
    .count_EN    (count_EN),
    .P_DATA      (P_DATA),
    .Data_Valid  (Data_Valid),
    .Parity_Error(Parity_Error),
    .Stop_Error  (Stop_Error)
  );

  always #5 CLK = ~CLK;

  // Edge_Bit_Counter model: edges run 1..Prescale, bit count steps on the last edge.
  always @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      edge_count <= 5'd1;
      bit_count  <= 4'd0;
    end else if (!count_EN) begin
      edge_count <= 5'd1;
      bit_count  <= 4'd0;
    end else if (edge_count == Prescale) begin
      edge_count <= 5'd1;
      bit_count  <= bit_count + 4'd1;
    end else begin
      edge_count <= edge_count + 5'd1;
    end
  end
  assign Last_edge = (edge_count == Prescale);

  always @(negedge CLK) begin
    if (Data_Valid) begin
      dv_cnt    <= dv_cnt + 1;
      last_data <= P_DATA;
    end
    if (Parity_Error) pe_cnt <= pe_cnt + 1;
    if (Stop_Error)   se_cnt <= se_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    b_dv = dv_cnt;
    b_pe = pe_cnt;
    b_se = se_cnt;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1 RX_IN = 1'b1;
    end
  endtask

  // Drives one frame; spike_bit/spike_off insert a single low cycle, abort_bit stops mid-frame.
  task automatic send_frame(input logic [7:0] data, input logic par_en, input logic par_bit,
                            input logic stop_bit, input int spike_bit, input int spike_off,
                            input int abort_bit);
    logic bits [12];
    int   nb;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = data[i];
    nb = 9;
    if (par_en) begin
      bits[nb] = par_bit;
      nb++;
    end
    bits[nb] = stop_bit;
    nb++;
    $display("frame data=0x%02h par_en=%0b par=%0b stop=%0b prescale=%0d", data, par_en,
             par_bit, stop_bit, Prescale);
    for (int k = 0; k < nb; k++) begin
      for (int c = 0; c < int'(Prescale); c++) begin
        if (k == abort_bit && c == 2) return;
        @(posedge CLK);
        #1 RX_IN = (k == spike_bit && c == spike_off) ? 1'b0 : bits[k];
      end
    end
  endtask

  task automatic check_frame(input string tag, input int dv, input int pe, input int se);
    check_val({tag, "_dv"}, dv_cnt - b_dv, dv);
    check_val({tag, "_pe"}, pe_cnt - b_pe, pe);
    check_val({tag, "_se"}, se_cnt - b_se, se);
  endtask

  initial begin
    Reset    = 1'b0;
    RX_IN    = 1'b1;
    Prescale = 5'd8;
    PAR_EN   = 1'b0;
    PAR_TYP  = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check_val("rst_count_en", count_EN, 0);
    check_val("rst_p_data", P_DATA, 0);
    check_val("rst_dv", Data_Valid, 0);
    check_val("rst_pe", Parity_Error, 0);
    check_val("rst_se", Stop_Error, 0);
    Reset = 1'b1;
    idle(4);

    // 1: plain frame
    snap();
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, -1, 0, -1);
    idle(12);
    check_frame("t1", 1, 0, 0);
    check_val("t1_word", last_data, 8'hA5);
    check_val("t1_p_data", P_DATA, 8'hA5);
    check_val("t1_count_en", count_EN, 0);

    // 2: even parity, good then bad parity bit
    PAR_EN = 1'b1;
    PAR_TYP = 1'b0;
    snap();
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, -1, 0, -1);
    idle(12);
    check_frame("t2a", 1, 0, 0);
    check_val("t2a_word", last_data, 8'h3C);
    snap();
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, -1, 0, -1);
    idle(12);
    check_frame("t2b", 0, 1, 0);
    check_val("t2b_p_data", P_DATA, 8'h3C);

    // 3: stop bit low, with parity config flipped mid-frame (must be ignored)
    PAR_EN = 1'b0;
    snap();
    fork
      send_frame(8'h55, 1'b0, 1'b0, 1'b0, -1, 0, -1);
      begin
        repeat (20) @(posedge CLK);
        #2 PAR_EN = 1'b1;
      end
    join
    idle(12);
    PAR_EN = 1'b0;
    check_frame("t3", 0, 0, 1);
    check_val("t3_p_data", P_DATA, 8'h3C);

    // 4: start glitch
    snap();
    @(posedge CLK);
    #1 RX_IN = 1'b0;
    @(posedge CLK);
    #1 RX_IN = 1'b0;
    check_val("t4_count_en_on", count_EN, 1);
    idle(24);
    check_val("t4_count_en_off", count_EN, 0);
    check_frame("t4", 0, 0, 0);

    // 5: one-cycle low spike on the middle sample of data bit 0
    snap();
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 1, 4, -1);
    idle(12);
    check_frame("t5", 1, 0, 0);
    check_val("t5_word", last_data, 8'hFF);

    // 6: Prescale 5, back-to-back frames, then reset mid-frame
    Prescale = 5'd5;
    idle(4);
    snap();
    send_frame(8'h01, 1'b0, 1'b0, 1'b1, -1, 0, -1);
    check_val("t6_word1", P_DATA, 8'hFF);
    send_frame(8'h80, 1'b0, 1'b0, 1'b1, -1, 0, -1);
    idle(8);
    check_frame("t6", 2, 0, 0);
    check_val("t6_word2", last_data, 8'h80);
    check_val("t6_p_data", P_DATA, 8'h80);
    snap();
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, -1, 0, 4);
    check_val("t6_mid_count_en", count_EN, 1);
    #2 Reset = 1'b0;
    RX_IN = 1'b1;
    #1;
    check_val("t6_rst_count_en", count_EN, 0);
    check_val("t6_rst_p_data", P_DATA, 0);
    check_val("t6_rst_dv", Data_Valid, 0);
    check_val("t6_rst_pe", Parity_Error, 0);
    check_val("t6_rst_se", Stop_Error, 0);
    repeat (2) @(posedge CLK);
    #1 Reset = 1'b1;
    idle(30);
    check_frame("t6_after_rst", 0, 0, 0);
    check_val("t6_after_count_en", count_EN, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
